// File: rtl/bullsCows_pkg.sv
// Shared types and helpers for the Bulls & Cows game engine.
package bullsCows_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SECRET = 3'd1,
        GUESS  = 3'd2,
        WIN    = 3'd3,
        DRAW   = 3'd4
    } bcg_state_t;

    // Width needed to hold a count from 0 to digits inclusive.
    function automatic int score_w(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/bcg_scorer.sv
// Combinational bulls/cows scorer: DIGITS x DIGITS symbol comparators plus
// a duplicate-symbol detector on the entered vector.
module bcg_scorer
    import bullsCows_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic [DIGITS*DIGIT_W-1:0]   guess,
    input  logic [DIGITS*DIGIT_W-1:0]   secret,
    output logic [score_w(DIGITS)-1:0]  bulls,
    output logic [score_w(DIGITS)-1:0]  cows,
    output logic                        dup
);

    localparam int SW = score_w(DIGITS);

    always_comb begin
        int nb;
        int nm;
        logic d;
        nb = 0;
        nm = 0;
        d  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (guess[i*DIGIT_W +: DIGIT_W] == secret[j*DIGIT_W +: DIGIT_W]) begin
                    nm = nm + 1;
                    if (i == j) nb = nb + 1;
                end
                if (j > i && guess[i*DIGIT_W +: DIGIT_W] == guess[j*DIGIT_W +: DIGIT_W])
                    d = 1'b1;
            end
        end
        // Cows exclude positional matches, which were also counted in nm.
        bulls = SW'(nb);
        cows  = SW'(nm - nb);
        dup   = d;
    end

endmodule

// File: rtl/bulls_cows_engine.sv
// N-player Bulls & Cows game engine: confirm edge detection, secret entry,
// round-robin guessing with scoring, and WIN/DRAW outcomes.
module bulls_cows_engine
    import bullsCows_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIGIT_W    = 4,
    parameter int PLAYERS    = 2,
    parameter int MAX_ROUNDS = 10
) (
    input  logic                         clock,
    input  logic                         CPU_RESETN,
    input  logic [DIGITS*DIGIT_W-1:0]    guess,
    input  logic                         confirm,
    output bcg_state_t                   state,
    output logic [$clog2(PLAYERS)-1:0]   player,
    output logic [score_w(DIGITS)-1:0]   bulls,
    output logic [score_w(DIGITS)-1:0]   cows,
    output logic                         score_valid,
    output logic                         err,
    output logic [7:0]                   round,
    output logic [$clog2(PLAYERS)-1:0]   winner
);

    localparam int PW = $clog2(PLAYERS);
    localparam int SW = score_w(DIGITS);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(PLAYERS - 1);

    logic                      conf_q;
    logic                      cedge;
    logic [DIGITS*DIGIT_W-1:0] secret [PLAYERS];
    logic [PW-1:0]             opp;
    logic [SW-1:0]             s_bulls;
    logic [SW-1:0]             s_cows;
    logic                      s_dup;

    bcg_state_t    state_nx;
    logic [PW-1:0] player_nx;
    logic [PW-1:0] winner_nx;
    logic [SW-1:0] bulls_nx;
    logic [SW-1:0] cows_nx;
    logic [7:0]    round_nx;
    logic          score_valid_nx;
    logic          err_nx;
    logic          wr_secret;

    assign cedge = confirm & ~conf_q;
    assign opp   = (player == LAST_PLAYER) ? '0 : player + 1'b1;

    bcg_scorer #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_scorer (
        .guess  (guess),
        .secret (secret[opp]),
        .bulls  (s_bulls),
        .cows   (s_cows),
        .dup    (s_dup)
    );

    always_comb begin
        state_nx       = state;
        player_nx      = player;
        winner_nx      = winner;
        bulls_nx       = bulls;
        cows_nx        = cows;
        round_nx       = round;
        score_valid_nx = 1'b0;
        err_nx         = 1'b0;
        wr_secret      = 1'b0;

        if (cedge) begin
            case (state)
                IDLE: begin
                    state_nx  = SECRET;
                    player_nx = '0;
                end
                SECRET: begin
                    if (s_dup) begin
                        err_nx = 1'b1;
                    end else begin
                        wr_secret = 1'b1;
                        if (player == LAST_PLAYER) begin
                            state_nx  = GUESS;
                            player_nx = '0;
                            round_nx  = 8'd1;
                        end else begin
                            player_nx = player + 1'b1;
                        end
                    end
                end
                GUESS: begin
                    // A rejected guess consumes no try and leaves the scores alone.
                    if (s_dup) begin
                        err_nx = 1'b1;
                    end else begin
                        bulls_nx       = s_bulls;
                        cows_nx        = s_cows;
                        score_valid_nx = 1'b1;
                        if (s_bulls == SW'(DIGITS)) begin
                            state_nx  = WIN;
                            winner_nx = player;
                        end else if (player == LAST_PLAYER) begin
                            if (round == 8'(MAX_ROUNDS)) begin
                                state_nx = DRAW;
                            end else begin
                                round_nx  = round + 8'd1;
                                player_nx = '0;
                            end
                        end else begin
                            player_nx = player + 1'b1;
                        end
                    end
                end
                WIN, DRAW: begin
                    state_nx  = IDLE;
                    bulls_nx  = '0;
                    cows_nx   = '0;
                    round_nx  = 8'd0;
                    player_nx = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state       <= IDLE;
            player      <= '0;
            winner      <= '0;
            bulls       <= '0;
            cows        <= '0;
            round       <= 8'd0;
            score_valid <= 1'b0;
            err         <= 1'b0;
            conf_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            player      <= player_nx;
            winner      <= winner_nx;
            bulls       <= bulls_nx;
            cows        <= cows_nx;
            round       <= round_nx;
            score_valid <= score_valid_nx;
            err         <= err_nx;
            conf_q      <= confirm;
        end
    end

    // Secrets survive a finished game and are simply overwritten by the next one.
    always_ff @(posedge clock) begin
        if (wr_secret) secret[player] <= guess;
    end

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed plus randomized bench for bulls_cows_engine, checked against a
// rule-level game model.
module tb_bulls_cows_engine;
    import bullsCows_pkg::*;

    localparam int DIGITS     = 4;
    localparam int DIGIT_W    = 4;
    localparam int PLAYERS    = 2;
    localparam int MAX_ROUNDS = 2;

    logic        clock;
    logic        CPU_RESETN;
    logic [15:0] guess;
    logic        confirm;
    bcg_state_t  state;
    logic [0:0]  player;
    logic [2:0]  bulls;
    logic [2:0]  cows;
    logic        score_valid;
    logic        err;
    logic [7:0]  round;
    logic [0:0]  winner;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bcg_state_t  m_state;
    int          m_player, m_bulls, m_cows, m_round, m_winner;
    int          exp_sv, exp_err;
    logic [15:0] m_secret [PLAYERS];

    bulls_cows_engine #(
        .DIGITS     (DIGITS),
        .DIGIT_W    (DIGIT_W),
        .PLAYERS    (PLAYERS),
        .MAX_ROUNDS (MAX_ROUNDS)
    ) dut (
        .clock       (clock),
        .CPU_RESETN  (CPU_RESETN),
        .guess       (guess),
        .confirm     (confirm),
        .state       (state),
        .player      (player),
        .bulls       (bulls),
        .cows        (cows),
        .score_valid (score_valid),
        .err         (err),
        .round       (round),
        .winner      (winner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ":state"},       int'(state),       int'(m_state));
        check({ctx, ":player"},      int'(player),      m_player);
        check({ctx, ":bulls"},       int'(bulls),       m_bulls);
        check({ctx, ":cows"},        int'(cows),        m_cows);
        check({ctx, ":round"},       int'(round),       m_round);
        check({ctx, ":winner"},      int'(winner),      m_winner);
        check({ctx, ":score_valid"}, int'(score_valid), exp_sv);
        check({ctx, ":err"},         int'(err),         exp_err);
    endtask

    function automatic bit distinct(input logic [15:0] v);
        bit seen [16];
        for (int k = 0; k < 16; k++) seen[k] = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (seen[v[4*i +: 4]]) return 1'b0;
            seen[v[4*i +: 4]] = 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state  = IDLE;
        m_player = 0;
        m_bulls  = 0;
        m_cows   = 0;
        m_round  = 0;
        m_winner = 0;
        exp_sv   = 0;
        exp_err  = 0;
    endtask

    // One confirmed entry, applied by the rules of the game.
    task automatic model_step(input logic [15:0] v);
        int b, m, target;
        exp_sv  = 0;
        exp_err = 0;
        case (m_state)
            IDLE: begin
                m_state  = SECRET;
                m_player = 0;
            end
            SECRET: begin
                if (!distinct(v)) exp_err = 1;
                else begin
                    m_secret[m_player] = v;
                    if (m_player == PLAYERS - 1) begin
                        m_state = GUESS; m_player = 0; m_round = 1;
                    end else m_player++;
                end
            end
            GUESS: begin
                if (!distinct(v)) exp_err = 1;
                else begin
                    target = (m_player + 1) % PLAYERS;
                    b = 0; m = 0;
                    for (int i = 0; i < DIGITS; i++)
                        for (int j = 0; j < DIGITS; j++)
                            if (v[4*i +: 4] == m_secret[target][4*j +: 4]) begin
                                m++;
                                if (i == j) b++;
                            end
                    m_bulls = b;
                    m_cows  = m - b;
                    exp_sv  = 1;
                    if (b == DIGITS) begin
                        m_state = WIN; m_winner = m_player;
                    end else if (m_player == PLAYERS - 1) begin
                        if (m_round == MAX_ROUNDS) m_state = DRAW;
                        else begin m_round++; m_player = 0; end
                    end else m_player++;
                end
            end
            default: begin
                m_state = IDLE;
                m_bulls = 0; m_cows = 0; m_round = 0; m_player = 0;
            end
        endcase
    endtask

    task automatic press(input logic [15:0] v, input string tag);
        @(negedge clock);
        guess   = v;
        confirm = 1'b1;
        model_step(v);
        @(posedge clock); #1;
        check_all({tag, "/act"});
        @(negedge clock);
        confirm = 1'b0;
        exp_sv  = 0;
        exp_err = 0;
        @(posedge clock); #1;
        check_all({tag, "/after"});
    endtask

    function automatic logic [15:0] rand_entry();
        logic [15:0] v;
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        do v = 16'($urandom); while (!distinct(v));
        return v;
    endfunction

    initial begin
        CPU_RESETN = 1'b0;
        confirm    = 1'b0;
        guess      = 16'h0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all("reset");
        @(negedge clock);
        CPU_RESETN = 1'b1;

        // Holding confirm high for 10 cycles advances exactly once.
        @(negedge clock);
        confirm = 1'b1;
        model_step(16'h0);
        @(posedge clock); #1;
        check_all("hold/act");
        exp_sv = 0; exp_err = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clock); #1;
            check_all("hold/still");
        end
        @(negedge clock);
        confirm = 1'b0;

        // Secret entry with a rejected duplicate, then the default game.
        press(16'h1123, "sec_dup");
        press(16'h1234, "sec_p0");
        press(16'h5678, "sec_p1");
        press(16'h1123, "gs_dup");
        press(16'h8765, "p0_8765");
        press(16'h1234, "p1_win");
        press(16'h0000, "win_exit");

        // No correct guesses: draw after MAX_ROUNDS full rounds.
        press(16'h0000, "g2_start");
        press(16'h1234, "g2_sec0");
        press(16'h5678, "g2_sec1");
        press(16'h9ABC, "g2_r1p0");
        press(16'hDEF0, "g2_r1p1");
        press(16'h2143, "g2_r2p0");
        check("draw_pre:round", int'(round), 2);
        press(16'h4321, "g2_draw");
        check("draw:state", int'(state), int'(DRAW));
        press(16'h0000, "draw_exit");

        // Asynchronous reset in the middle of GUESS.
        press(16'h0000, "g3_start");
        press(16'hABCD, "g3_sec0");
        press(16'h1357, "g3_sec1");
        press(16'h8765, "g3_p0");
        @(posedge clock); #3;
        CPU_RESETN = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        CPU_RESETN = 1'b1;

        // Randomized play against the model.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] v;
            v = rand_entry();
            if (m_state == GUESS && $urandom_range(0, 4) == 0)
                v = m_secret[(m_player + 1) % PLAYERS];
            press(v, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
